// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: walks signed xpos/ypos through porches, sync and active video,
// drives aligned hsync/vsync/data_en, and exposes CTRL/LINE_CMP/STATUS/FRAME over MMIO with irq.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  output logic               hsync,
  output logic               vsync,
  output logic               data_en,
  output logic signed [15:0] xpos,
  output logic signed [15:0] ypos,
  input  logic               sel,
  input  logic [3:0]         wstrb,
  input  logic [3:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               irq
);

  localparam int HBL = H_FP + H_SYNC + H_BP;
  localparam int VBL = V_FP + V_SYNC + V_BP;

  localparam logic signed [15:0] X_MIN  = 16'(-HBL);
  localparam logic signed [15:0] X_MAX  = 16'(H_ACTIVE - 1);
  localparam logic signed [15:0] HS_BEG = 16'(H_FP - HBL);
  localparam logic signed [15:0] HS_END = 16'(-H_BP - 1);
  localparam logic signed [15:0] Y_MIN  = 16'(-VBL);
  localparam logic signed [15:0] Y_MAX  = 16'(V_ACTIVE - 1);
  localparam logic signed [15:0] VS_BEG = 16'(V_FP - VBL);
  localparam logic signed [15:0] VS_END = 16'(-V_BP - 1);

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_LCMP = 4'h4;
  localparam logic [3:0] A_STAT = 4'h8;
  localparam logic [3:0] A_INFO = 4'hC;

  // pixel counters and registered video outputs
  logic signed [15:0] r_x;
  logic signed [15:0] r_y;
  logic               r_hs;
  logic               r_vs;
  logic               r_de;

  // register file
  logic [2:0]         r_ctrl;
  logic signed [15:0] r_line_cmp;
  logic [1:0]         r_status;
  logic [15:0]        r_frame;
  logic               r_ready;
  logic [31:0]        r_rdata;

  logic               w_en;
  logic               w_line_end;
  logic               w_wrap;
  logic signed [15:0] w_x_nxt;
  logic signed [15:0] w_y_nxt;
  logic               w_hs_on;
  logic               w_vs_on;
  logic               w_de_nxt;
  logic               w_line_hit;
  logic               w_acc;
  logic               w_wr;
  logic [1:0]         w_stat_set;
  logic [1:0]         w_stat_clr;
  logic [31:0]        w_rd_dat;
  logic               w_unused;

  assign w_en       = r_ctrl[0];
  assign w_line_end = (r_x == X_MAX);
  assign w_wrap     = w_en && w_line_end && (r_y == Y_MAX);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (!w_en) begin
      w_x_nxt = X_MIN;
      w_y_nxt = Y_MIN;
    end else if (w_line_end) begin
      w_x_nxt = X_MIN;
      w_y_nxt = (r_y == Y_MAX) ? Y_MIN : r_y + 16'sd1;
    end else begin
      w_x_nxt = r_x + 16'sd1;
    end
  end

  // Syncs and data_en are decoded from the next position so they line up with xpos/ypos.
  assign w_hs_on  = (w_x_nxt >= HS_BEG) && (w_x_nxt <= HS_END);
  assign w_vs_on  = (w_y_nxt >= VS_BEG) && (w_y_nxt <= VS_END);
  assign w_de_nxt = w_en && !w_x_nxt[15] && !w_y_nxt[15];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x  <= X_MIN;
      r_y  <= Y_MIN;
      r_hs <= ~H_SYNC_POL;
      r_vs <= ~V_SYNC_POL;
      r_de <= 1'b0;
    end else begin
      r_x  <= w_x_nxt;
      r_y  <= w_y_nxt;
      r_hs <= (w_en && w_hs_on) ? H_SYNC_POL : ~H_SYNC_POL;
      r_vs <= (w_en && w_vs_on) ? V_SYNC_POL : ~V_SYNC_POL;
      r_de <= w_de_nxt;
    end
  end

  // Flags also track the next position, so they become visible in the matching pixel cycle.
  assign w_line_hit = (w_x_nxt == X_MIN) && (w_y_nxt == r_line_cmp);
  assign w_acc      = sel && !r_ready;
  assign w_wr       = w_acc && (|wstrb);
  assign w_stat_set = {w_wrap, w_line_hit};
  assign w_stat_clr = (w_wr && (addr == A_STAT) && wstrb[0]) ? wdata[1:0] : 2'b00;

  always_comb begin
    w_rd_dat = 32'd0;
    case (addr)
      A_CTRL:  w_rd_dat = {29'd0, r_ctrl};
      A_LCMP:  w_rd_dat = {16'd0, r_line_cmp};
      A_STAT:  w_rd_dat = {30'd0, r_status};
      A_INFO:  w_rd_dat = {r_y, r_frame};
      default: w_rd_dat = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_status <= 2'b00;
      r_frame  <= 16'd0;
    end else begin
      r_status <= (r_status & ~w_stat_clr) | w_stat_set;
      if (w_wrap) begin
        r_frame <= r_frame + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ctrl     <= 3'b001;
      r_line_cmp <= 16'sd0;
      r_ready    <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_acc ? w_rd_dat : 32'd0;
      if (w_wr && (addr == A_CTRL) && wstrb[0]) begin
        r_ctrl <= wdata[2:0];
      end
      if (w_wr && (addr == A_LCMP)) begin
        if (wstrb[0]) r_line_cmp[7:0]  <= wdata[7:0];
        if (wstrb[1]) r_line_cmp[15:8] <= wdata[15:8];
      end
    end
  end

  assign w_unused = ^wdata[31:16];

  assign hsync   = r_hs;
  assign vsync   = r_vs;
  assign data_en = r_de;
  assign xpos    = r_x;
  assign ypos    = r_y;
  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign irq     = |(r_status & r_ctrl[2:1]);

endmodule
